instr_sequencer: RTL



---
 rtl/instr_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute sequencer FSM for the single-issue core
// Optional feature macro: SEQ_COMPRESSED_EN (compressed instructions, 2-byte jump alignment)
module instr_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    WORD_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [WORD_WIDTH-1:0] imem_rdata_i,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  cycle_counter_o,
  output logic                  instr_valid_o,
  input  logic                  ctrl_trans_inst_i,
  input  logic                  compressed_inst_i,
  input  logic                  illegal_inst_i,
  input  logic [WORD_WIDTH-1:0] alu_result_i,
  output logic                  halted_o,
  output logic [31:0]           instret_o
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC0 = 3'd3,
    S_EXEC1 = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [WORD_WIDTH-1:0] NOP_WORD = WORD_WIDTH'(32'h0000_0013);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pc, pc_next;
  logic [ADDR_WIDTH-1:0]   instr_addr;
  logic [WORD_WIDTH-1:0]   instr;
  logic [31:0]             instret, instret_next;
  logic                    instr_load;
  logic                    exec0_illegal;
  logic                    target_misaligned;
  logic [ADDR_WIDTH-1:0]   jump_target;
  logic [ADDR_WIDTH-1:0]   seq_step;

`ifdef SEQ_COMPRESSED_EN
  assign exec0_illegal     = illegal_inst_i;
  assign target_misaligned = 1'b0;
`else
  // Without compressed support a compressed encoding or a halfword target is a fault.
  assign exec0_illegal     = illegal_inst_i | compressed_inst_i;
  assign target_misaligned = alu_result_i[1];
`endif

  assign jump_target = ADDR_WIDTH'(alu_result_i) & ~ADDR_WIDTH'(1);
  assign seq_step    = compressed_inst_i ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    instret_next    = instret;
    instr_load      = 1'b0;
    imem_req_o      = 1'b0;
    cycle_counter_o = 1'b0;
    instr_valid_o   = 1'b0;
    halted_o        = 1'b0;
    case (state)
      S_BOOT: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          instr_load = 1'b1;
          state_next = S_EXEC0;
        end
      end
      S_EXEC0: begin
        instr_valid_o = ~exec0_illegal;
        if (exec0_illegal) begin
          state_next = S_HALT;
        end else if (ctrl_trans_inst_i) begin
          state_next = S_EXEC1;
        end else begin
          pc_next      = pc + seq_step;
          instret_next = instret + 32'd1;
          state_next   = S_FETCH;
        end
      end
      S_EXEC1: begin
        cycle_counter_o = 1'b1;
        instr_valid_o   = 1'b1;
        if (target_misaligned) begin
          state_next = S_HALT;
        end else begin
          pc_next      = jump_target;
          instret_next = instret + 32'd1;
          state_next   = S_FETCH;
        end
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_ADDR;
      instret <= 32'd0;
    end else begin
      pc      <= pc_next;
      instret <= instret_next;
    end
  end

  // The decoder sees the instruction and its own PC frozen until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr      <= NOP_WORD;
      instr_addr <= RESET_ADDR;
    end else if (instr_load) begin
      instr      <= imem_rdata_i;
      instr_addr <= pc;
    end
  end

  assign imem_addr_o  = pc;
  assign instr_o      = instr;
  assign instr_addr_o = instr_addr;
  assign instret_o    = instret;

endmodule
